// File: rtl/rotary_encoder_pkg.sv
// rtl/rotary_encoder_pkg.sv - shared types for the rotary encoder block family
package rotary_encoder_pkg;

    typedef enum logic {
        SLOW_E = 1'b0,
        FAST_E = 1'b1
    } speed_t;

    typedef logic rotation_t;

    localparam rotation_t ROT_LEFT_C  = 1'b0;
    localparam rotation_t ROT_RIGHT_C = 1'b1;

endpackage

// File: rtl/rotary_encoder_accel.sv
// rtl/rotary_encoder_accel.sv - detent interval tracking and step-size selection
module rotary_encoder_accel
    import rotary_encoder_pkg::*;
#(
    parameter int COUNTER_WIDTH_P = 16,
    parameter int ACCEL_WINDOW_P  = 50000,
    parameter int ACCEL_STREAK_P  = 4,
    parameter int ACCEL_STEP_P    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_change,
    input  logic                       rotation_direction,
    input  logic                       accel_en,
    output logic [COUNTER_WIDTH_P-1:0] step
);

    localparam int IW  = $clog2(ACCEL_WINDOW_P + 1);
    localparam int SKW = $clog2(ACCEL_STREAK_P + 1);

    localparam logic [IW-1:0]              WINDOW_C    = IW'(ACCEL_WINDOW_P);
    localparam logic [SKW-1:0]             STREAK_C    = SKW'(ACCEL_STREAK_P);
    localparam logic [COUNTER_WIDTH_P-1:0] FAST_STEP_C = COUNTER_WIDTH_P'(ACCEL_STEP_P);
    localparam logic [COUNTER_WIDTH_P-1:0] UNIT_STEP_C = COUNTER_WIDTH_P'(1);

    speed_t          speed_q, speed_d;
    logic [IW-1:0]   interval_q, interval_d;
    logic [SKW-1:0]  streak_q, streak_d;
    rotation_t       last_dir_q, last_dir_d;
    logic            is_fast;
    logic            same_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q    <= SLOW_E;
            interval_q <= WINDOW_C;
            streak_q   <= '0;
            last_dir_q <= ROT_LEFT_C;
        end else begin
            speed_q    <= speed_d;
            interval_q <= interval_d;
            streak_q   <= streak_d;
            last_dir_q <= last_dir_d;
        end
    end

    always_comb begin
        interval_d = interval_q;
        if (valid_change) begin
            interval_d = '0;
        end else if (interval_q != WINDOW_C) begin
            interval_d = interval_q + 1'b1;
        end

        is_fast    = (interval_q < WINDOW_C);
        same_dir   = (rotation_direction == last_dir_q);
        last_dir_d = valid_change ? rotation_direction : last_dir_q;

        speed_d  = speed_q;
        streak_d = streak_q;
        step     = UNIT_STEP_C;

        if (!accel_en) begin
            speed_d  = SLOW_E;
            streak_d = '0;
        end else begin
            case (speed_q)
                SLOW_E: begin
                    if (valid_change) begin
                        streak_d = (is_fast && same_dir) ? streak_q + 1'b1 : SKW'(1);
                        if (streak_d >= STREAK_C) begin
                            speed_d = FAST_E;
                        end
                    end
                end
                FAST_E: begin
                    step = FAST_STEP_C;
                    // Leaving FAST as the interval saturates means any later detent sees SLOW.
                    if (valid_change) begin
                        if (!same_dir) begin
                            speed_d  = SLOW_E;
                            streak_d = SKW'(1);
                            step     = UNIT_STEP_C;
                        end
                    end else if (interval_d == WINDOW_C) begin
                        speed_d  = SLOW_E;
                        streak_d = '0;
                    end
                end
                default: begin
                    speed_d  = SLOW_E;
                    streak_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rotary_encoder_counter.sv
// rtl/rotary_encoder_counter.sv - bounded position accumulator with saturate/wrap and acceleration
module rotary_encoder_counter
    import rotary_encoder_pkg::*;
#(
    parameter int COUNTER_WIDTH_P = 16,
    parameter int MIN_P           = 0,
    parameter int MAX_P           = 255,
    parameter int INIT_P          = 0,
    parameter int ACCEL_WINDOW_P  = 50000,
    parameter int ACCEL_STREAK_P  = 4,
    parameter int ACCEL_STEP_P    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_change,
    input  logic                       rotation_direction,
    input  logic                       cfg_wrap,
    input  logic                       cfg_accel_en,
    input  logic                       load,
    input  logic [COUNTER_WIDTH_P-1:0] load_value,
    output logic [COUNTER_WIDTH_P-1:0] counter_value,
    output logic                       counter_valid,
    output logic                       at_min,
    output logic                       at_max
);

    localparam int SW = COUNTER_WIDTH_P + 2;

    localparam logic [COUNTER_WIDTH_P-1:0] MIN_C  = COUNTER_WIDTH_P'(MIN_P);
    localparam logic [COUNTER_WIDTH_P-1:0] MAX_C  = COUNTER_WIDTH_P'(MAX_P);
    localparam logic [COUNTER_WIDTH_P-1:0] INIT_C = COUNTER_WIDTH_P'(INIT_P);
    localparam logic signed [SW-1:0]       MIN_S  = SW'(MIN_P);
    localparam logic signed [SW-1:0]       MAX_S  = SW'(MAX_P);
    localparam logic signed [SW-1:0]       SPAN_S = SW'(MAX_P - MIN_P + 1);

    logic [COUNTER_WIDTH_P-1:0] step;
    logic [COUNTER_WIDTH_P-1:0] value_q, value_d;
    logic [COUNTER_WIDTH_P-1:0] load_clamped;
    logic [COUNTER_WIDTH_P-1:0] detent_value;
    logic signed [SW-1:0]       cur_s, step_s, sum_s, bounded_s, load_s;
    logic                       valid_q, valid_d;
    logic                       at_min_q, at_min_d;
    logic                       at_max_q, at_max_d;

    rotary_encoder_accel #(
        .COUNTER_WIDTH_P (COUNTER_WIDTH_P),
        .ACCEL_WINDOW_P  (ACCEL_WINDOW_P),
        .ACCEL_STREAK_P  (ACCEL_STREAK_P),
        .ACCEL_STEP_P    (ACCEL_STEP_P)
    ) u_accel (
        .clk                (clk),
        .rst                (rst),
        .valid_change       (valid_change),
        .rotation_direction (rotation_direction),
        .accel_en           (cfg_accel_en),
        .step               (step)
    );

    always_comb begin
        cur_s  = $signed({2'b00, value_q});
        step_s = $signed({2'b00, step});
        sum_s  = (rotation_direction == ROT_RIGHT_C) ? cur_s + step_s : cur_s - step_s;

        // Step never exceeds the span, so a single wrap correction is enough.
        bounded_s = sum_s;
        if (sum_s > MAX_S) begin
            bounded_s = cfg_wrap ? sum_s - SPAN_S : MAX_S;
        end else if (sum_s < MIN_S) begin
            bounded_s = cfg_wrap ? sum_s + SPAN_S : MIN_S;
        end
        detent_value = COUNTER_WIDTH_P'(bounded_s);

        load_s       = $signed({2'b00, load_value});
        load_clamped = load_value;
        if (load_s < MIN_S) begin
            load_clamped = MIN_C;
        end else if (load_s > MAX_S) begin
            load_clamped = MAX_C;
        end

        value_d = value_q;
        if (load) begin
            value_d = load_clamped;
        end else if (valid_change) begin
            value_d = detent_value;
        end

        valid_d  = (value_d != value_q);
        at_min_d = (value_d == MIN_C);
        at_max_d = (value_d == MAX_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q  <= INIT_C;
            valid_q  <= 1'b0;
            at_min_q <= (INIT_C == MIN_C);
            at_max_q <= (INIT_C == MAX_C);
        end else begin
            value_q  <= value_d;
            valid_q  <= valid_d;
            at_min_q <= at_min_d;
            at_max_q <= at_max_d;
        end
    end

    assign counter_value = value_q;
    assign counter_valid = valid_q;
    assign at_min        = at_min_q;
    assign at_max        = at_max_q;

endmodule

// File: tb/tb_rotary_encoder_counter.sv
// tb/tb_rotary_encoder_counter.sv - directed vector table plus randomized model comparison
module tb_rotary_encoder_counter;

    localparam int W      = 16;
    localparam int MIN    = 0;
    localparam int MAX    = 255;
    localparam int INIT   = 0;
    localparam int WIN    = 50;
    localparam int STREAK = 4;
    localparam int STEP   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_change;
    logic         rotation_direction;
    logic         cfg_wrap;
    logic         cfg_accel_en;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] counter_value;
    logic         counter_valid;
    logic         at_min;
    logic         at_max;

    always #5 clk = ~clk;

    rotary_encoder_counter #(
        .COUNTER_WIDTH_P (W),
        .MIN_P           (MIN),
        .MAX_P           (MAX),
        .INIT_P          (INIT),
        .ACCEL_WINDOW_P  (WIN),
        .ACCEL_STREAK_P  (STREAK),
        .ACCEL_STEP_P    (STEP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .valid_change       (valid_change),
        .rotation_direction (rotation_direction),
        .cfg_wrap           (cfg_wrap),
        .cfg_accel_en       (cfg_accel_en),
        .load               (load),
        .load_value         (load_value),
        .counter_value      (counter_value),
        .counter_valid      (counter_valid),
        .at_min             (at_min),
        .at_max             (at_max)
    );

    typedef struct {
        int idle;
        bit r;
        bit vc;
        bit d;
        bit wr;
        bit ac;
        bit ld;
        int ldv;
        int exp_val;
        bit exp_pulse;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;

    int m_val = INIT;
    bit m_fast = 0;
    int m_streak = 0;
    bit m_has_det = 0;
    int m_last_det = 0;
    bit m_last_dir = 0;
    int m_cyc = 0;
    bit m_pulse = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int idle, input bit r, input bit vc, input bit d,
                                input bit wr, input bit ac, input bit ld, input int ldv,
                                input int ev, input bit ep);
        vec_t v;
        v.idle = idle; v.r = r; v.vc = vc; v.d = d; v.wr = wr; v.ac = ac;
        v.ld = ld; v.ldv = ldv; v.exp_val = ev; v.exp_pulse = ep;
        return v;
    endfunction

    // Reference: position arithmetic on ints, "fast" judged from cycle stamps of detents.
    task automatic model(input bit r, input bit vc, input bit d, input bit wr,
                         input bit ac, input bit ld, input int ldv);
        int old;
        int stp;
        int nxt;
        bit recent;
        m_cyc++;
        if (r) begin
            m_val = INIT; m_pulse = 0; m_fast = 0; m_streak = 0;
            m_has_det = 0; m_last_dir = 0;
            return;
        end
        old = m_val;
        stp = 1;
        recent = m_has_det && ((m_cyc - m_last_det) <= WIN);
        if (!ac) begin
            m_fast = 0;
            m_streak = 0;
        end else if (vc) begin
            if (m_fast && !recent) begin
                m_fast = 0;
                m_streak = 0;
            end
            if (m_fast) begin
                if (d != m_last_dir) begin
                    m_fast = 0;
                    m_streak = 1;
                end else begin
                    stp = STEP;
                end
            end else begin
                m_streak = (recent && d == m_last_dir) ? m_streak + 1 : 1;
                if (m_streak >= STREAK) m_fast = 1;
            end
        end
        if (vc) begin
            m_last_dir = d;
            m_last_det = m_cyc;
            m_has_det = 1;
        end
        if (ld) begin
            m_val = (ldv < MIN) ? MIN : (ldv > MAX) ? MAX : ldv;
        end else if (vc) begin
            nxt = d ? m_val + stp : m_val - stp;
            if (nxt > MAX) nxt = wr ? nxt - (MAX - MIN + 1) : MAX;
            else if (nxt < MIN) nxt = wr ? nxt + (MAX - MIN + 1) : MIN;
            m_val = nxt;
        end
        m_pulse = (m_val != old);
    endtask

    task automatic cycle(input bit r, input bit vc, input bit d, input bit wr,
                         input bit ac, input bit ld, input int ldv);
        @(negedge clk);
        rst = r;
        valid_change = vc;
        rotation_direction = d;
        cfg_wrap = wr;
        cfg_accel_en = ac;
        load = ld;
        load_value = ldv[W-1:0];
        @(posedge clk);
        #1;
        model(r, vc, d, wr, ac, ld, ldv);
    endtask

    initial begin
        vec_t v;
        int   gaps[4];
        int   gapmax;
        int   countdown;
        bit   wr;
        bit   ac;
        bit   dir;
        bit   vc;
        bit   ld;
        bit   r;
        int   ldv;

        rst = 1'b1; valid_change = 1'b0; rotation_direction = 1'b0;
        cfg_wrap = 1'b0; cfg_accel_en = 1'b0; load = 1'b0; load_value = '0;

        //            idle rst vc d wr ac ld ldv  val pulse
        tbl.push_back(mk(0,   1, 0, 0, 0, 1, 0, 0,   0,   0));
        tbl.push_back(mk(100, 0, 1, 1, 0, 1, 0, 0,   1,   1));
        tbl.push_back(mk(100, 0, 1, 1, 0, 1, 0, 0,   2,   1));
        tbl.push_back(mk(100, 0, 1, 1, 0, 1, 0, 0,   3,   1));
        tbl.push_back(mk(5,   0, 0, 0, 0, 0, 1, 254, 254, 1));
        tbl.push_back(mk(0,   0, 1, 1, 0, 0, 0, 0,   255, 1));
        tbl.push_back(mk(0,   0, 1, 1, 0, 0, 0, 0,   255, 0));
        tbl.push_back(mk(0,   0, 1, 1, 0, 0, 0, 0,   255, 0));
        tbl.push_back(mk(2,   0, 0, 0, 1, 0, 1, 1,   1,   1));
        tbl.push_back(mk(0,   0, 1, 0, 1, 0, 0, 0,   0,   1));
        tbl.push_back(mk(0,   0, 1, 0, 1, 0, 0, 0,   255, 1));
        tbl.push_back(mk(0,   0, 1, 0, 1, 0, 0, 0,   254, 1));
        tbl.push_back(mk(0,   0, 0, 0, 1, 0, 1, 0,   0,   1));
        tbl.push_back(mk(60,  0, 1, 1, 0, 1, 0, 0,   1,   1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   2,   1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   3,   1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   4,   1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   12,  1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   20,  1));
        tbl.push_back(mk(9,   0, 1, 0, 0, 1, 0, 0,   19,  1));
        tbl.push_back(mk(60,  0, 1, 1, 0, 1, 0, 0,   20,  1));
        tbl.push_back(mk(3,   0, 1, 1, 0, 1, 1, 300, 255, 1));
        tbl.push_back(mk(60,  0, 0, 0, 0, 1, 1, 96,  96,  1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   97,  1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   98,  1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   99,  1));
        tbl.push_back(mk(9,   0, 1, 1, 0, 1, 0, 0,   100, 1));
        tbl.push_back(mk(2,   1, 1, 1, 0, 1, 0, 0,   0,   0));
        tbl.push_back(mk(2,   0, 1, 1, 0, 1, 0, 0,   1,   1));
        tbl.push_back(mk(1,   0, 1, 0, 0, 0, 0, 0,   0,   1));
        tbl.push_back(mk(0,   0, 1, 0, 0, 0, 0, 0,   0,   0));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 1, 0,   0,   0));
        tbl.push_back(mk(0,   0, 0, 0, 0, 0, 1, 255, 255, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            for (int k = 0; k < v.idle; k++) begin
                cycle(0, 0, 0, v.wr, v.ac, 0, 0);
                chk($sformatf("row%0d_idle_pulse", i), int'(counter_valid), 0);
            end
            cycle(v.r, v.vc, v.d, v.wr, v.ac, v.ld, v.ldv);
            chk($sformatf("row%0d_value", i), int'(counter_value), v.exp_val);
            chk($sformatf("row%0d_pulse", i), int'(counter_valid), int'(v.exp_pulse));
            chk($sformatf("row%0d_at_min", i), int'(at_min), int'(v.exp_val == MIN));
            chk($sformatf("row%0d_at_max", i), int'(at_max), int'(v.exp_val == MAX));
        end

        gaps[0] = 2; gaps[1] = 12; gaps[2] = 45; gaps[3] = 70;
        dir = 1'b1;
        cycle(1, 0, 0, 0, 1, 0, 0);
        for (int seg = 0; seg < 16; seg++) begin
            wr = 1'($urandom % 2);
            ac = (($urandom % 4) != 0);
            gapmax = gaps[$urandom % 4];
            countdown = $urandom_range(1, gapmax);
            for (int c = 0; c < 250; c++) begin
                vc = 1'b0;
                countdown--;
                if (countdown == 0) begin
                    vc = 1'b1;
                    countdown = $urandom_range(1, gapmax);
                    if (($urandom % 8) == 0) dir = ~dir;
                end
                ld  = (($urandom % 64) == 0);
                ldv = $urandom_range(0, 400);
                r   = (($urandom % 700) == 0);
                cycle(r, vc, dir, wr, ac, ld, ldv);
                chk($sformatf("rnd%0d_value", m_cyc), int'(counter_value), m_val);
                chk($sformatf("rnd%0d_pulse", m_cyc), int'(counter_valid), int'(m_pulse));
                chk($sformatf("rnd%0d_at_min", m_cyc), int'(at_min), int'(m_val == MIN));
                chk($sformatf("rnd%0d_at_max", m_cyc), int'(at_max), int'(m_val == MAX));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rotary_encoder_counter.md
# rotary_encoder_counter

Position accumulator downstream of the rotary encoder FSM. Consumes the single-cycle `valid_change` / `rotation_direction` detent events and maintains a bounded unsigned position value with selectable saturate/wrap behaviour. Optional velocity acceleration raises the step size during fast, same-direction rotation. Its output feeds register-map readback and parameter-control logic (volume, menu index).

## Interface
**Parameters**
- `COUNTER_WIDTH_P`, 16, width of the position value.
- `MIN_P`, 0, lowest legal position.
- `MAX_P`, 255, highest legal position; `MIN_P < MAX_P < 2**COUNTER_WIDTH_P`.
- `INIT_P`, 0, position after reset; `MIN_P <= INIT_P <= MAX_P`.
- `ACCEL_WINDOW_P`, 50000, maximum cycles between detents that still count as "fast".
- `ACCEL_STREAK_P`, 4, consecutive fast same-direction detents needed to enter FAST.
- `ACCEL_STEP_P`, 8, step size in FAST; `1 <= ACCEL_STEP_P <= MAX_P-MIN_P+1`.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `valid_change` in 1: one-cycle detent event.
- `rotation_direction` in 1: 1 = right/increment, 0 = left/decrement; sampled only with `valid_change`.
- `cfg_wrap` in 1: 1 = wrap at bounds, 0 = saturate.
- `cfg_accel_en` in 1: 0 forces a step of 1 and holds the speed state at SLOW.
- `load` in 1: one-cycle load strobe.
- `load_value` in COUNTER_WIDTH_P: value to load; clamped to `[MIN_P, MAX_P]`.
- `counter_value` out COUNTER_WIDTH_P: current position.
- `counter_valid` out 1: one-cycle pulse when `counter_value` changes.
- `at_min` out 1: `counter_value == MIN_P`.
- `at_max` out 1: `counter_value == MAX_P`.

## Operation
- Reset values:
  - `counter_value = INIT_P`
  - `counter_valid = 0`
  - `at_min` and `at_max` are registered and reflect `INIT_P`.
  - Speed state is SLOW, streak = 0, interval counter = `ACCEL_WINDOW_P` (saturated).
  - Last direction = 0.
- Interval counter:
  - Increments every cycle and saturates at `ACCEL_WINDOW_P`.
  - Clears to 0 on each `valid_change`.
  - "Fast" means interval < `ACCEL_WINDOW_P` when `valid_change` arrives.
- Speed FSM (`speed_t`: SLOW_E, FAST_E):
  - SLOW_E, on a detent:
    - Fast and same direction as the last detent: streak+1.
    - Otherwise: streak = 1.
    - When streak reaches `ACCEL_STREAK_P`: go to FAST_E. That detent still uses step 1.
  - FAST_E:
    - Step = `ACCEL_STEP_P`.
    - Interval saturating at `ACCEL_WINDOW_P`: go to SLOW_E, streak = 0.
    - Detent with direction reversed: go to SLOW_E, streak = 1; that detent uses step 1.
  - `cfg_accel_en = 0`: force SLOW_E, streak = 0.
- Arithmetic:
  - next = value ± step, computed in `COUNTER_WIDTH_P+2` signed bits.
  - Saturate mode: clamp to `[MIN_P, MAX_P]`.
  - Wrap mode, next > MAX_P: next − (MAX_P−MIN_P+1).
  - Wrap mode, next < MIN_P: next + (MAX_P−MIN_P+1).
- `load` has priority over a simultaneous `valid_change`:
  - The detent is dropped for position.
  - The detent still updates the interval counter, streak and direction.
- `counter_valid` pulses only if the new value differs from the old one. Saturating at a bound, or loading the current value, gives no pulse.

## Timing
- `valid_change` or `load` sampled at edge n → `counter_value`, `at_min`, `at_max` and `counter_valid` update at edge n+1. Latency 1 cycle.
- `counter_valid` is high for exactly one cycle per change.
- Back-to-back detents on consecutive cycles are each accepted. No input is ever stalled; there is no backpressure.
- Speed state update happens in the same cycle as the detent. The step used is the one selected by the state *before* the update, except on a reversal in FAST_E, which uses step 1.
- `rst` asserted mid-operation returns every output to its reset value on the next edge. Any in-flight detent is discarded.

## Structure
- Shared package `rotary_encoder_pkg` holds:
  - `speed_t` enum.
  - `rotation_t` constants: `ROT_LEFT_C = 0`, `ROT_RIGHT_C = 1`.
  - Future encoder-family typedefs.
- Sub-module `rotary_encoder_accel`:
  - Contains the interval counter, streak counter, speed FSM and last direction.
  - Output: `step` (COUNTER_WIDTH_P wide).
- The top level holds the position register, bound arithmetic, load mux and flags.

## Test plan
- Reset, then 3 right detents 100 cycles apart with `ACCEL_WINDOW_P = 50` → values 1, 2, 3, each with one `counter_valid` pulse one cycle after its detent.
- Saturate mode, `MAX_P = 255`, value 254, 3 right detents → 255 then no change; 1 `counter_valid` pulse; `at_max = 1`.
- Wrap mode, value 1, `MIN_P = 0`, `MAX_P = 255`, accel off, 3 left detents → 0, 255, 254.
- Accel on, `ACCEL_STREAK_P = 4`, `ACCEL_STEP_P = 8`, 6 right detents 10 cycles apart, from value 0:
  - Values 1, 2, 3, 4, 12, 20.
  - Then 1 left detent → 19, state SLOW_E.
  - Then idle ≥ 50 cycles, then 1 right detent → step 1.
- `load` with `load_value = 300` (MAX 255) in the same cycle as a right detent → value 255, one pulse, detent ignored for position.
- Assert `rst` while in FAST_E at value 100 → next edge: value `INIT_P`, flags reset, SLOW_E; the next detent steps by 1.
